tlb_op_ctrl: RTL
================

# tlb_op_ctrl

Sequencer that executes the TLB management instructions TLBSRCH, TLBRD, TLBWR, TLBFILL and INVTLB against the 16-entry TLB, acting as the initiator on the TLB's write, read and search-port-1 interfaces. It sits between the pipeline's commit stage and CSR file on one side and the TLB on the other. It borrows search port 1 from the load/store path for one cycle during TLBSRCH and INVTLB, and returns CSR write-back results through a one-cycle done pulse.

## Interface
Parameters:
- TLBNUM, 16, TLB entry count; IDXW = $clog2(TLBNUM)

Entry packing (89 bits), used by every `*_entry` bus:
- {e, vppn[18:0], ps[5:0], asid[9:0], g, lo0[25:0], lo1[25:0]}
- lo = {ppn[19:0], mat[1:0], plv[1:0], d, v}

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- op_valid / op_ready  in / out  1 / 1  request handshake
- op_code  in  3  0 SRCH, 1 RD, 2 WR, 3 FILL, 4 INV, 5-7 reserved
- op_inv  in  5  INVTLB op field
- op_inv_asid  in  10  INVTLB rj ASID
- op_inv_va  in  19  INVTLB rk VA[31:13]
- op_cancel  in  1  abort while in ISSUE
- csr_idx  in  IDXW  TLBIDX.index
- csr_ps  in  6  TLBIDX.ps
- csr_ne  in  1  TLBIDX.ne
- csr_vppn  in  19  TLBEHI.vppn
- csr_asid  in  10  ASID.asid
- csr_lo0, csr_lo1  in  27  {ppn, g, mat, plv, d, v}
- csr_refill  in  1  ESTAT.ecode == TLBR
- pipe_s1_vppn  in  20  load/store search VPPN
- pipe_s1_asid  in  10  load/store search ASID
- tlb_s1_vppn  out  20  search port 1 VPPN
- tlb_s1_asid  out  10  search port 1 ASID
- tlb_s1_found  in  1  search port 1 hit
- tlb_s1_index  in  IDXW  search port 1 hit index
- port_busy  out  1  search port 1 owned by this block
- tlb_invtlb_op  out  5  invalidate opcode to TLB
- tlb_we  out  1  TLB write enable
- tlb_w_index  out  IDXW  TLB write index
- tlb_w_entry  out  89  TLB write entry
- tlb_r_index  out  IDXW  TLB read index
- tlb_r_entry  in  89  TLB read entry
- done  out  1  one-cycle result pulse
- done_op  out  3  op_code of the finished op
- res_err  out  1  reserved op code or INVTLB op > 6
- res_ne  out  1  TLBIDX.ne write-back
- res_idx  out  IDXW  TLBIDX.index write-back
- res_entry  out  89  TLBRD result

## Operation
- FSM states: IDLE, ISSUE, RESP. op_ready = (state == IDLE).
- IDLE → ISSUE on op_valid & op_ready. At this edge, capture op_code, op_inv*, every csr_* input, and fill_cnt.
- ISSUE → RESP. If op_cancel is high in ISSUE: no TLB side effect, go to IDLE, no done pulse.
- RESP → IDLE. done = 1 for one cycle; result registers are driven.
- fill_cnt: free-running IDXW-bit counter, increments every cycle, wraps TLBNUM-1 → 0. FILL writes at the count captured at accept.
- WR/FILL in ISSUE: tlb_we = 1.
  - tlb_w_index = captured csr_idx (WR) or captured fill_cnt (FILL).
  - Entry fields: e = ~ne | refill; vppn, ps, asid from CSRs; g = lo0.g & lo1.g.
- RD: tlb_r_index = captured csr_idx during ISSUE; tlb_r_entry is registered at the ISSUE edge.
  - If e = 1: res_entry = read value, res_ne = 0.
  - If e = 0: res_entry = 0, res_ne = 1.
- SRCH in ISSUE: tlb_s1_vppn = {vppn, 1'b0}, tlb_s1_asid = csr_asid.
  - Hit: res_ne = 0, res_idx = tlb_s1_index.
  - Miss: res_ne = 1, res_idx = captured csr_idx.
- INV in ISSUE: tlb_invtlb_op = op_inv; tlb_s1_vppn = {op_inv_va, 1'b0}; tlb_s1_asid = op_inv_asid.
  - op_inv > 6: tlb_invtlb_op = 0 and res_err = 1.
- Reserved op_code: no TLB activity, res_err = 1.
- Outside ISSUE, and in ISSUE for RD/WR/FILL:
  - tlb_s1_* pass pipe_s1_* through combinationally.
  - port_busy = 0.
  - tlb_invtlb_op = 0.
  - tlb_we = 0.
- port_busy = 1 only in ISSUE for SRCH/INV.

## Timing
- Reset values: state IDLE, op_ready 1, done 0, tlb_we 0, tlb_invtlb_op 0, port_busy 0, fill_cnt 0, all res_* 0.
- Latency: accept at edge t → TLB access in cycle t+1 → done high in cycle t+2.
- The next accept is possible at edge t+3.
- tlb_we and tlb_invtlb_op are asserted for exactly one cycle and never together.
- CSR or op input changes after accept do not affect the op in flight.
- op_cancel is ignored in IDLE and RESP.
- reset asserted mid-op returns the FSM to IDLE immediately. If reset is asserted while tlb_we is high, the write is dropped.

## Test plan
- WR with csr_idx = 5, vppn = 0x12345, ps = 12, ne = 0, lo0.g = lo1.g = 1 → tlb_we pulse at t+1 with index 5, e = 1, g = 1; done at t+2.
- SRCH for entry 5 with matching asid → res_ne = 0, res_idx = 5. Repeat with vppn = 0x00001 → res_ne = 1, res_idx = captured csr_idx.
- RD index 5 → res_entry equals the written entry. RD of an invalid index 7 → res_ne = 1, res_entry = 0.
- FILL accepted when fill_cnt = 15 → write index 15; the counter then wraps to 0. With ne = 1 and refill = 1 → e = 1.
- INV op 5 with asid 0x3 and va 0x12345 → tlb_invtlb_op = 5 for one cycle and port_busy = 1. INV op 9 → tlb_invtlb_op = 0, res_err = 1.
- op_cancel in ISSUE of WR → tlb_we stays 0 and no done pulse; op_ready returns 1 the next cycle.

Source files
------------

// File: rtl/tlb_op_ctrl_if.sv
// TLB-side port bundle: search port 1, write port, read port and invalidate opcode.
// The sequencer is the master; the TLB array is the slave.
interface tlb_op_ctrl_if #(
    parameter int TLBNUM = 16
);
    localparam int IDXW = $clog2(TLBNUM);

    logic [19:0]     s1_vppn;
    logic [9:0]      s1_asid;
    logic            s1_found;
    logic [IDXW-1:0] s1_index;
    logic            port_busy;
    logic [4:0]      invtlb_op;
    logic            we;
    logic [IDXW-1:0] w_index;
    logic [88:0]     w_entry;
    logic [IDXW-1:0] r_index;
    logic [88:0]     r_entry;

    modport master (
        output s1_vppn, s1_asid, port_busy, invtlb_op, we, w_index, w_entry, r_index,
        input  s1_found, s1_index, r_entry
    );

    modport slave (
        input  s1_vppn, s1_asid, port_busy, invtlb_op, we, w_index, w_entry, r_index,
        output s1_found, s1_index, r_entry
    );
endinterface

// File: rtl/tlb_op_ctrl.sv
// Sequencer for TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB: accept, one TLB access cycle,
// then a one-cycle done pulse carrying the CSR write-back results.
module tlb_op_ctrl #(
    parameter  int TLBNUM = 16,
    localparam int IDXW   = $clog2(TLBNUM)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            op_valid,
    output logic            op_ready,
    input  logic [2:0]      op_code,
    input  logic [4:0]      op_inv,
    input  logic [9:0]      op_inv_asid,
    input  logic [18:0]     op_inv_va,
    input  logic            op_cancel,
    input  logic [IDXW-1:0] csr_idx,
    input  logic [5:0]      csr_ps,
    input  logic            csr_ne,
    input  logic [18:0]     csr_vppn,
    input  logic [9:0]      csr_asid,
    input  logic [26:0]     csr_lo0,
    input  logic [26:0]     csr_lo1,
    input  logic            csr_refill,
    input  logic [19:0]     pipe_s1_vppn,
    input  logic [9:0]      pipe_s1_asid,
    tlb_op_ctrl_if.master   tlb,
    output logic            done,
    output logic [2:0]      done_op,
    output logic            res_err,
    output logic            res_ne,
    output logic [IDXW-1:0] res_idx,
    output logic [88:0]     res_entry
);
    // state  | meaning
    // IDLE   | ready for a new op
    // ISSUE  | TLB access cycle (write / read / search / invalidate)
    // RESP   | done pulse, results valid
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    localparam logic [2:0] OP_SRCH = 3'd0;
    localparam logic [2:0] OP_RD   = 3'd1;
    localparam logic [2:0] OP_WR   = 3'd2;
    localparam logic [2:0] OP_FILL = 3'd3;
    localparam logic [2:0] OP_INV  = 3'd4;

    state_t          state_q, state_d;
    logic [IDXW-1:0] fill_cnt_q, fill_cnt_d;
    logic [IDXW-1:0] fill_idx_q, fill_idx_d;
    logic [2:0]      op_q, op_d;
    logic [4:0]      inv_q, inv_d;
    logic [9:0]      inv_asid_q, inv_asid_d;
    logic [18:0]     inv_va_q, inv_va_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [5:0]      ps_q, ps_d;
    logic            ne_q, ne_d;
    logic [18:0]     vppn_q, vppn_d;
    logic [9:0]      asid_q, asid_d;
    logic [26:0]     lo0_q, lo0_d;
    logic [26:0]     lo1_q, lo1_d;
    logic            refill_q, refill_d;
    logic            res_err_q, res_err_d;
    logic            res_ne_q, res_ne_d;
    logic [IDXW-1:0] res_idx_q, res_idx_d;
    logic [88:0]     res_entry_q, res_entry_d;

    logic issue_go;
    logic inv_ok;
    logic is_write;
    logic is_search;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            fill_cnt_q  <= '0;
            fill_idx_q  <= '0;
            op_q        <= '0;
            inv_q       <= '0;
            inv_asid_q  <= '0;
            inv_va_q    <= '0;
            idx_q       <= '0;
            ps_q        <= '0;
            ne_q        <= 1'b0;
            vppn_q      <= '0;
            asid_q      <= '0;
            lo0_q       <= '0;
            lo1_q       <= '0;
            refill_q    <= 1'b0;
            res_err_q   <= 1'b0;
            res_ne_q    <= 1'b0;
            res_idx_q   <= '0;
            res_entry_q <= '0;
        end else begin
            state_q     <= state_d;
            fill_cnt_q  <= fill_cnt_d;
            fill_idx_q  <= fill_idx_d;
            op_q        <= op_d;
            inv_q       <= inv_d;
            inv_asid_q  <= inv_asid_d;
            inv_va_q    <= inv_va_d;
            idx_q       <= idx_d;
            ps_q        <= ps_d;
            ne_q        <= ne_d;
            vppn_q      <= vppn_d;
            asid_q      <= asid_d;
            lo0_q       <= lo0_d;
            lo1_q       <= lo1_d;
            refill_q    <= refill_d;
            res_err_q   <= res_err_d;
            res_ne_q    <= res_ne_d;
            res_idx_q   <= res_idx_d;
            res_entry_q <= res_entry_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        fill_cnt_d  = (fill_cnt_q == IDXW'(TLBNUM - 1)) ? '0 : fill_cnt_q + 1'b1;
        fill_idx_d  = fill_idx_q;
        op_d        = op_q;
        inv_d       = inv_q;
        inv_asid_d  = inv_asid_q;
        inv_va_d    = inv_va_q;
        idx_d       = idx_q;
        ps_d        = ps_q;
        ne_d        = ne_q;
        vppn_d      = vppn_q;
        asid_d      = asid_q;
        lo0_d       = lo0_q;
        lo1_d       = lo1_q;
        refill_d    = refill_q;
        res_err_d   = res_err_q;
        res_ne_d    = res_ne_q;
        res_idx_d   = res_idx_q;
        res_entry_d = res_entry_q;

        case (state_q)
            S_IDLE: begin
                if (op_valid) begin
                    state_d    = S_ISSUE;
                    fill_idx_d = fill_cnt_q;
                    op_d       = op_code;
                    inv_d      = op_inv;
                    inv_asid_d = op_inv_asid;
                    inv_va_d   = op_inv_va;
                    idx_d      = csr_idx;
                    ps_d       = csr_ps;
                    ne_d       = csr_ne;
                    vppn_d     = csr_vppn;
                    asid_d     = csr_asid;
                    lo0_d      = csr_lo0;
                    lo1_d      = csr_lo1;
                    refill_d   = csr_refill;
                end
            end
            S_ISSUE: begin
                if (op_cancel) begin
                    state_d = S_IDLE;
                end else begin
                    state_d     = S_RESP;
                    // Index write-back defaults to the unchanged TLBIDX.index
                    res_err_d   = 1'b0;
                    res_ne_d    = 1'b0;
                    res_idx_d   = idx_q;
                    res_entry_d = '0;
                    case (op_q)
                        OP_SRCH: begin
                            res_ne_d = ~tlb.s1_found;
                            if (tlb.s1_found) res_idx_d = tlb.s1_index;
                        end
                        OP_RD: begin
                            res_ne_d    = ~tlb.r_entry[88];
                            res_entry_d = tlb.r_entry[88] ? tlb.r_entry : '0;
                        end
                        OP_WR, OP_FILL: ;
                        OP_INV:  res_err_d = ~inv_ok;
                        default: res_err_d = 1'b1;
                    endcase
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign issue_go  = (state_q == S_ISSUE) && !op_cancel;
    assign inv_ok    = (inv_q <= 5'd6);
    assign is_write  = (op_q == OP_WR) || (op_q == OP_FILL);
    assign is_search = (op_q == OP_SRCH) || (op_q == OP_INV);

    assign tlb.we        = issue_go && is_write;
    assign tlb.w_index   = (op_q == OP_FILL) ? fill_idx_q : idx_q;
    // CSR lo carries g at bit 6; the entry keeps a single g = lo0.g & lo1.g
    assign tlb.w_entry   = {~ne_q | refill_q, vppn_q, ps_q, asid_q, lo0_q[6] & lo1_q[6],
                            lo0_q[26:7], lo0_q[5:0], lo1_q[26:7], lo1_q[5:0]};
    assign tlb.r_index   = idx_q;
    assign tlb.invtlb_op = (issue_go && (op_q == OP_INV) && inv_ok) ? inv_q : 5'd0;
    assign tlb.port_busy = issue_go && is_search;
    assign tlb.s1_vppn   = !tlb.port_busy   ? pipe_s1_vppn :
                           (op_q == OP_INV) ? {inv_va_q, 1'b0} : {vppn_q, 1'b0};
    assign tlb.s1_asid   = !tlb.port_busy   ? pipe_s1_asid :
                           (op_q == OP_INV) ? inv_asid_q : asid_q;

    assign op_ready  = (state_q == S_IDLE);
    assign done      = (state_q == S_RESP);
    assign done_op   = op_q;
    assign res_err   = res_err_q;
    assign res_ne    = res_ne_q;
    assign res_idx   = res_idx_q;
    assign res_entry = res_entry_q;
endmodule
